thread_dispatch_scheduler: RTL
==============================

THREAD_DISPATCH_SCHEDULER -- requirements
Module: thread_dispatch_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4, number of ray cores served.
REQ-002 Parameter COORD_W, default 10, screen coordinate width.
REQ-003 Parameter MAX_INFLIGHT, default 16, frame-wide cap on issued-but-unretired threads.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle frame start request.
REQ-007 abort  input  1  synchronous frame cancel.
REQ-008 fb_width  input  COORD_W  pixels per row, sampled on accepted start.
REQ-009 fb_height  input  COORD_W  rows per frame, sampled on accepted start.
REQ-010 core_full  input  NUM_CORES  per-core input FIFO full.
REQ-011 retire  input  NUM_CORES  per-core pulse, one pixel completed.
REQ-012 issue_valid  output  NUM_CORES  one-hot (or zero) thread dispatch strobe.
REQ-013 issue_x  output  COORD_W  pixel x of current issue.
REQ-014 issue_y  output  COORD_W  pixel y of current issue.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 frame_done  output  1  single-cycle frame completion pulse.
REQ-017 inflight  output  $clog2(MAX_INFLIGHT+1)  outstanding thread count.

Function
REQ-018 States: IDLE, ISSUE, DRAIN, DONE; all outputs registered.
REQ-019 IDLE: start high -> latch fb_width/fb_height, cursor (0,0), rr pointer 0, -> ISSUE; start in other states ignored.
REQ-020 start with fb_width==0 or fb_height==0 -> DONE directly, no issue.
REQ-021 ISSUE: at most one issue per cycle; eligible core = first index with core_full low, searching from rr pointer upward, wrapping modulo NUM_CORES.
REQ-022 Issue occurs only if an eligible core exists and inflight < MAX_INFLIGHT; otherwise issue_valid all zero, cursor holds.
REQ-023 On issue: issue_valid bit of chosen core high for exactly one cycle with issue_x/issue_y = cursor; rr pointer <- chosen+1 modulo NUM_CORES.
REQ-024 Cursor raster order: x+1; x==fb_width-1 -> x=0, y+1.
REQ-025 Issue of pixel (fb_width-1, fb_height-1) -> DRAIN.
REQ-026 inflight next = inflight + issue - popcount(retire); simultaneous issue and retire net correctly in one cycle.
REQ-027 retire while inflight==0 ignored (saturate at 0).
REQ-028 DRAIN: no issue; inflight==0 -> DONE.
REQ-029 DONE: frame_done high one cycle, -> IDLE.
REQ-030 abort in ISSUE/DRAIN/DONE -> IDLE next cycle, issue_valid zero, inflight cleared, no frame_done; abort has priority over start and retire.
REQ-031 Latency: start accepted at edge N -> first possible issue_valid at edge N+1.

Reset
REQ-032 resetn low: state IDLE, issue_valid 0, issue_x/issue_y 0, busy 0, frame_done 0, inflight 0, rr pointer 0, immediately and independent of clk.
REQ-033 Reset mid-frame discards frame; no frame_done generated.

Structure
REQ-034 Shared package holds state enum ThreadSchedState, RAY_CORE_SIZE (NUM_CORES default), SCREEN_COORD width.
REQ-035 One combinational sub-module rr_core_picker: inputs core_full, pointer; outputs found, one-hot grant, index.

Verification
REQ-036 fb 4x2, core_full=0, retire each issue 3 cycles later -> 8 issues on cores 0,1,2,3,0,1,2,3, coords (0,0)..(3,1), one frame_done.
REQ-037 core_full=4'b0101, pointer 0 -> grants core1, then core3, then core1.
REQ-038 MAX_INFLIGHT=16, no retire -> exactly 16 issues then stall; one retire -> exactly one more issue.
REQ-039 Same-cycle issue and retire on 2 cores at inflight 5 -> inflight 4.
REQ-040 abort in DRAIN with inflight 3 -> IDLE, inflight 0, frame_done never asserted.
REQ-041 start with fb_width 0 -> frame_done 2 cycles later, no issue_valid.

Source files
------------

// File: rtl/thread_dispatch_scheduler_pkg.sv
// Shared types and sizes for the thread dispatch scheduler.
// Holds the FSM state enum and default core/coordinate sizes.
package thread_dispatch_scheduler_pkg;

  localparam int RAY_CORE_SIZE = 4;
  localparam int SCREEN_COORD  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } ThreadSchedState;

endpackage

// File: rtl/thread_dispatch_scheduler_picker.sv
// Round-robin picker: first non-full core at or above pointer.
// In: core_full, pointer. Out: found, one-hot grant, index.
module rr_core_picker
  import thread_dispatch_scheduler_pkg::*;
#(
  parameter int NUM_CORES = RAY_CORE_SIZE,
  parameter int PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] core_full,
  input  logic [PTR_W-1:0]     pointer,
  output logic                 found,
  output logic [NUM_CORES-1:0] grant,
  output logic [PTR_W-1:0]     index
);

  always_comb begin
    found = 1'b0;
    grant = '0;
    index = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      int c;
      c = (int'(pointer) + i) % NUM_CORES;
      if (!found && !core_full[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        index    = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/thread_dispatch_scheduler.sv
// Raster-order pixel thread dispatcher over NUM_CORES ray cores.
// In: start/abort, fb size, core_full, retire. Out: issue strobe+xy, busy, frame_done, inflight.
module thread_dispatch_scheduler
  import thread_dispatch_scheduler_pkg::*;
#(
  parameter int NUM_CORES    = RAY_CORE_SIZE,
  parameter int COORD_W      = SCREEN_COORD,
  parameter int MAX_INFLIGHT = 16,
  localparam int IW    = $clog2(MAX_INFLIGHT + 1),
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [COORD_W-1:0]   fb_width,
  input  logic [COORD_W-1:0]   fb_height,
  input  logic [NUM_CORES-1:0] core_full,
  input  logic [NUM_CORES-1:0] retire,
  output logic [NUM_CORES-1:0] issue_valid,
  output logic [COORD_W-1:0]   issue_x,
  output logic [COORD_W-1:0]   issue_y,
  output logic                 busy,
  output logic                 frame_done,
  output logic [IW-1:0]        inflight
);

  ThreadSchedState state_q, state_d;
  logic [COORD_W-1:0]   w_q, w_d, h_q, h_d;
  logic [COORD_W-1:0]   cur_x_q, cur_x_d;
  logic [COORD_W-1:0]   cur_y_q, cur_y_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [NUM_CORES-1:0] issue_valid_q, issue_valid_d;
  logic [COORD_W-1:0]   issue_x_q, issue_x_d;
  logic [COORD_W-1:0]   issue_y_q, issue_y_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [IW-1:0]        inflight_q, inflight_d;

  logic                 pick_found;
  logic [NUM_CORES-1:0] pick_grant;
  logic [PTR_W-1:0]     pick_idx;
  logic                 do_issue;

  rr_core_picker #(
    .NUM_CORES(NUM_CORES),
    .PTR_W    (PTR_W)
  ) u_picker (
    .core_full(core_full),
    .pointer  (rr_q),
    .found    (pick_found),
    .grant    (pick_grant),
    .index    (pick_idx)
  );

  always_comb begin
    int cnt;
    state_d       = state_q;
    w_d           = w_q;
    h_d           = h_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    rr_d          = rr_q;
    issue_valid_d = '0;
    issue_x_d     = issue_x_q;
    issue_y_d     = issue_y_q;
    frame_done_d  = 1'b0;
    do_issue      = 1'b0;
    cnt           = 0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d     = fb_width;
          h_d     = fb_height;
          cur_x_d = '0;
          cur_y_d = '0;
          rr_d    = '0;
          state_d = (fb_width == '0 || fb_height == '0)
                    ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pick_found && inflight_q < IW'(MAX_INFLIGHT)) begin
          do_issue      = 1'b1;
          issue_valid_d = pick_grant;
          issue_x_d     = cur_x_q;
          issue_y_d     = cur_y_q;
          rr_d = (pick_idx == PTR_W'(NUM_CORES - 1))
                 ? '0 : pick_idx + PTR_W'(1);
          if (cur_x_q == w_q - COORD_W'(1)) begin
            cur_x_d = '0;
            if (cur_y_q == h_q - COORD_W'(1)) state_d = ST_DRAIN;
            else cur_y_d = cur_y_q + COORD_W'(1);
          end else begin
            cur_x_d = cur_x_q + COORD_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Net issue against retires in one step; clamp so stray
    // retires never wrap the counter below zero.
    cnt = int'(inflight_q) + (do_issue ? 1 : 0);
    for (int i = 0; i < NUM_CORES; i++) begin
      if (retire[i]) cnt = cnt - 1;
    end
    if (cnt < 0) cnt = 0;
    inflight_d = IW'(cnt);

    if (abort) begin
      state_d       = ST_IDLE;
      rr_d          = rr_q;
      issue_valid_d = '0;
      frame_done_d  = 1'b0;
      inflight_d    = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      w_q           <= '0;
      h_q           <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      rr_q          <= '0;
      issue_valid_q <= '0;
      issue_x_q     <= '0;
      issue_y_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      inflight_q    <= '0;
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      h_q           <= h_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      rr_q          <= rr_d;
      issue_valid_q <= issue_valid_d;
      issue_x_q     <= issue_x_d;
      issue_y_q     <= issue_y_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      inflight_q    <= inflight_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_x     = issue_x_q;
  assign issue_y     = issue_y_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign inflight    = inflight_q;

endmodule
